// File: rtl/mult_pkg.sv
// Shared constants, types and elaboration helpers for the pipelined Wallace multiplier.
package mult_pkg;

  localparam int MULT_LATENCY = 3;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mult_mode_e;

  // Row count entering a given reduction level (each 3:2 group removes one row).
  function automatic int rows_at_level(input int rows, input int level);
    int n;
    n = rows;
    for (int i = 0; i < level; i++) begin
      n = n - n / 3;
    end
    return n;
  endfunction

  function automatic int wallace_levels(input int rows);
    int n;
    int lv;
    n  = rows;
    lv = 0;
    while (n > 2) begin
      n  = n - n / 3;
      lv = lv + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/wallace_mult_pipe_csa_row.sv
// Vector 3:2 compressor built from fa cells; carry vector is pre-shifted left by one.
module csa_row #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-2:0] co_s;

  for (genvar i = 0; i < W - 1; i++) begin : g_fa
    fa u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (z[i]),
      .s  (s[i]),
      .co (co_s[i])
    );
  end

  // Top column's carry would land beyond the modulus, so only its sum is formed.
  assign s[W-1] = x[W-1] ^ y[W-1] ^ z[W-1];
  assign c      = {co_s, 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage WIDTH x WIDTH signed/unsigned multiplier: partial products, Wallace
// carry-save reduction, final add. Valid/ready on both sides with bubble collapsing.
module wallace_mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;
  localparam int NL = wallace_levels(NR);
  localparam logic [PW-1:0] BW_CORR = {1'b1, {(PW - WIDTH - 2){1'b0}}, 1'b1, {WIDTH{1'b0}}};

  logic                        v1_r, v2_r, v3_r;
  logic                        adv1_s, adv2_s, adv3_s;
  logic [WIDTH-1:0][WIDTH-1:0] pp_s;
  logic [WIDTH-1:0][WIDTH-1:0] pp1_r;
  mult_mode_e                  mode_s, mode1_r;
  logic [TAG_W-1:0]            tag1_r, tag2_r, tag3_r;
  logic [NR-1:0][PW-1:0]       rows_s;
  logic [PW-1:0]               sum_s, carry_s, sum2_r, carry2_r, prod3_r;

  assign adv3_s   = !v3_r || out_ready;
  assign adv2_s   = !v2_r || adv3_s;
  assign adv1_s   = !v1_r || adv2_s;
  assign in_ready = adv1_s;
  assign mode_s   = in_signed ? MODE_SIGNED : MODE_UNSIGNED;

  // Partial-product rows; signed mode applies the Baugh-Wooley term inversions.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp_s[i] = (in_a & {WIDTH{in_b[i]}}) ^
                (in_signed ? ((i == WIDTH - 1) ? {1'b0, {(WIDTH - 1){1'b1}}}
                                               : {1'b1, {(WIDTH - 1){1'b0}}})
                           : {WIDTH{1'b0}});
    end
  end

  // Align rows by weight and append the correction row for signed transactions.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      rows_s[i] = {{WIDTH{1'b0}}, pp1_r[i]} << i;
    end
    rows_s[NR-1] = (mode1_r == MODE_SIGNED) ? BW_CORR : {PW{1'b0}};
  end

  for (genvar k = 0; k < NL; k++) begin : g_lvl
    localparam int NIN  = rows_at_level(NR, k);
    localparam int NG   = NIN / 3;
    localparam int NOUT = NIN - NG;
    logic [NIN-1:0][PW-1:0]  cur;
    logic [NOUT-1:0][PW-1:0] nxt;

    if (k == 0) begin : g_src
      assign cur = rows_s;
    end else begin : g_src
      assign cur = g_lvl[k-1].nxt;
    end

    for (genvar i = 0; i < NG; i++) begin : g_csa
      csa_row #(.W(PW)) u_csa (
        .x (cur[3*i]),
        .y (cur[3*i+1]),
        .z (cur[3*i+2]),
        .s (nxt[2*i]),
        .c (nxt[2*i+1])
      );
    end

    // Rows left over after grouping in threes drop straight to the next level.
    for (genvar j = 2 * NG; j < NOUT; j++) begin : g_pass
      assign nxt[j] = cur[j + NG];
    end
  end

  assign sum_s   = g_lvl[NL-1].nxt[0];
  assign carry_s = g_lvl[NL-1].nxt[1];

  // Pipeline valid bits and data registers, each stage loading when it may advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      v3_r     <= 1'b0;
      pp1_r    <= '0;
      mode1_r  <= MODE_UNSIGNED;
      tag1_r   <= '0;
      tag2_r   <= '0;
      tag3_r   <= '0;
      sum2_r   <= '0;
      carry2_r <= '0;
      prod3_r  <= '0;
    end else begin
      if (adv1_s) begin
        v1_r    <= in_valid;
        pp1_r   <= pp_s;
        mode1_r <= mode_s;
        tag1_r  <= in_tag;
      end
      if (adv2_s) begin
        v2_r     <= v1_r;
        sum2_r   <= sum_s;
        carry2_r <= carry_s;
        tag2_r   <= tag1_r;
      end
      if (adv3_s) begin
        v3_r    <= v2_r;
        prod3_r <= sum2_r + carry2_r;
        tag3_r  <= tag2_r;
      end
    end
  end

  assign out_valid   = v3_r;
  assign out_product = prod3_r;
  assign out_tag     = tag3_r;
  assign busy        = v1_r | v2_r | v3_r;

endmodule
